fifo_sync_lsram_ctrl: RTL and testbench



---
 rtl/fifo_sync_pkg.sv | 20 ++
 rtl/fifo_sync_ram_dp.sv | 36 +++
 rtl/fifo_sync_lsram_ctrl.sv | 132 +++++++++++++
 tb/tb_fifo_sync_lsram_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared constants and helpers for the single-clock LSRAM FIFO.
// Provides pipeline-mode selectors, default thresholds and a ceil-log2 helper.
package fifo_sync_pkg;

  localparam int PIPE_NONE = 0;
  localparam int PIPE_OUT  = 1;

  localparam int AEMPTY_DEFAULT      = 4;
  localparam int AFULL_MARGIN_DEFAULT = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_ram_dp.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-before-write on address collision, so a read of the slot being overwritten returns the old word.
module fifo_sync_ram_dp
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array carries no reset so it maps onto the LSRAM block itself.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_sync_lsram_ctrl.sv
// Single-clock FIFO controller around a dual-port LSRAM with optional output pipeline.
// Flags are registered from the next-state occupancy so they are valid one cycle after each access.
module fifo_sync_lsram_ctrl
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 128,
  parameter int PIPE       = PIPE_OUT,
  parameter int AFULL_VAL  = DEPTH - AFULL_MARGIN_DEFAULT,
  parameter int AEMPTY_VAL = AEMPTY_DEFAULT
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        WDATA,
  input  logic                    WE,
  input  logic                    RE,
  output logic [WIDTH-1:0]        RDATA,
  output logic                    RDATA_VALID,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic                    AFULL,
  output logic                    AEMPTY,
  output logic [clog2(DEPTH):0]   COUNT,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_VAL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_VAL);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             rd_acc;
  logic             wr_acc;
  logic             ram_valid;
  logic [WIDTH-1:0] ram_q;

  // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
  always_comb begin
    rd_acc     = RE && (count != '0);
    wr_acc     = WE && ((count != DEPTH_C) || rd_acc);
    count_next = count;
    if (wr_acc && !rd_acc) begin
      count_next = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
      end
      count <= count_next;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      FULL      <= 1'b0;
      EMPTY     <= 1'b1;
      AFULL     <= 1'b0;
      AEMPTY    <= 1'b1;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
      ram_valid <= 1'b0;
    end else begin
      FULL      <= (count_next == DEPTH_C);
      EMPTY     <= (count_next == '0);
      AFULL     <= (count_next >= AFULL_C);
      AEMPTY    <= (count_next <= AEMPTY_C);
      OVERFLOW  <= WE && !wr_acc;
      UNDERFLOW <= RE && (count == '0);
      ram_valid <= rd_acc;
    end
  end

  assign COUNT = count;

  fifo_sync_ram_dp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (CLOCK),
    .rst   (RESET),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (WDATA),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (ram_q)
  );

  // The extra stage only captures on a valid word, so RDATA holds between reads in both modes.
  if (PIPE == PIPE_OUT) begin : g_pipe
    logic [WIDTH-1:0] out_q;
    logic             out_valid;

    always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
        out_q     <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= ram_valid;
        if (ram_valid) begin
          out_q <= ram_q;
        end
      end
    end

    assign RDATA       = out_q;
    assign RDATA_VALID = out_valid;
  end else begin : g_nopipe
    assign RDATA       = ram_q;
    assign RDATA_VALID = ram_valid;
  end

endmodule

// File: tb/tb_fifo_sync_lsram_ctrl.sv
// Scoreboard bench: two DEPTH=16 FIFOs (PIPE=0 and PIPE=1) share stimulus and a queue-based reference model.
// Directed corner cases are followed by biased random traffic.
module tb_fifo_sync_lsram_ctrl;

  localparam int W   = 32;
  localparam int D   = 16;
  localparam int CW  = 5;
  localparam int AFV = 12;
  localparam int AEV = 4;

  typedef struct packed {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          we    = 1'b0;
  logic          re    = 1'b0;
  logic [W-1:0]  wdata = '0;

  logic [W-1:0]  rdata0, rdata1;
  logic          rv0, rv1, full0, full1, empty0, empty1;
  logic          afull0, afull1, aempty0, aempty1;
  logic          ovf0, ovf1, unf0, unf1;
  logic [CW-1:0] count0, count1;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  logic [W-1:0]  model [$];
  exp_t          sb0 [$];
  exp_t          sb1 [$];
  logic [W-1:0]  last0 = '0;
  logic [W-1:0]  last1 = '0;

  fifo_sync_lsram_ctrl #(.WIDTH(W), .DEPTH(D), .PIPE(0)) u_p0 (
    .CLOCK(clk), .RESET(rst), .WDATA(wdata), .WE(we), .RE(re),
    .RDATA(rdata0), .RDATA_VALID(rv0), .FULL(full0), .EMPTY(empty0),
    .AFULL(afull0), .AEMPTY(aempty0), .COUNT(count0),
    .OVERFLOW(ovf0), .UNDERFLOW(unf0)
  );

  fifo_sync_lsram_ctrl #(.WIDTH(W), .DEPTH(D), .PIPE(1)) u_p1 (
    .CLOCK(clk), .RESET(rst), .WDATA(wdata), .WE(we), .RE(re),
    .RDATA(rdata1), .RDATA_VALID(rv1), .FULL(full1), .EMPTY(empty1),
    .AFULL(afull1), .AEMPTY(aempty1), .COUNT(count1),
    .OVERFLOW(ovf1), .UNDERFLOW(unf1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every valid word must match the oldest outstanding read at the right latency.
  task automatic mon(input int idx, input logic v, input logic [W-1:0] d);
    exp_t e;
    int   lat;
    bit   none;
    lat  = (idx == 0) ? 1 : 2;
    none = (idx == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
    if (v) begin
      if (none) begin
        total++;
        bad++;
        $display("[TB] FAIL p%0d_spurious_valid: got valid with data %0h, want no valid", idx, d);
      end else begin
        if (idx == 0) e = sb0.pop_front();
        else          e = sb1.pop_front();
        chk($sformatf("p%0d_rdata", idx), 64'(d), 64'(e.data));
        chk($sformatf("p%0d_latency", idx), 64'(cyc - e.cyc), 64'(lat));
      end
      if (idx == 0) last0 = d;
      else          last1 = d;
    end else begin
      chk($sformatf("p%0d_rdata_hold", idx), 64'(d), 64'((idx == 0) ? last0 : last1));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, rv0, rdata0);
      mon(1, rv1, rdata1);
    end
  end

  task automatic check_flags(input bit e_ovf, input bit e_unf);
    int n;
    n = model.size();
    chk("p0_count",     64'(count0),  64'(n));
    chk("p1_count",     64'(count1),  64'(n));
    chk("p0_full",      64'(full0),   64'(n == D));
    chk("p1_full",      64'(full1),   64'(n == D));
    chk("p0_empty",     64'(empty0),  64'(n == 0));
    chk("p1_empty",     64'(empty1),  64'(n == 0));
    chk("p0_afull",     64'(afull0),  64'(n >= AFV));
    chk("p1_afull",     64'(afull1),  64'(n >= AFV));
    chk("p0_aempty",    64'(aempty0), 64'(n <= AEV));
    chk("p1_aempty",    64'(aempty1), 64'(n <= AEV));
    chk("p0_overflow",  64'(ovf0),    64'(e_ovf));
    chk("p1_overflow",  64'(ovf1),    64'(e_ovf));
    chk("p0_underflow", 64'(unf0),    64'(e_unf));
    chk("p1_underflow", 64'(unf1),    64'(e_unf));
  endtask

  // One clock of stimulus; the reference model is a plain queue of stored words.
  task automatic applyStimulus(input bit w, input bit r, input logic [W-1:0] d);
    bit   rd_ok, wr_ok, e_ovf, e_unf;
    exp_t e;
    @(negedge clk);
    we    = w;
    re    = r;
    wdata = d;
    rd_ok = r && (model.size() > 0);
    wr_ok = w && ((model.size() < D) || rd_ok);
    e_ovf = w && !wr_ok;
    e_unf = r && (model.size() == 0);
    if (rd_ok) begin
      e.data = model.pop_front();
      e.cyc  = cyc;
      sb0.push_back(e);
      sb1.push_back(e);
    end
    if (wr_ok) model.push_back(d);
    @(posedge clk);
    #1;
    check_flags(e_ovf, e_unf);
  endtask

  task automatic checkOutput_reset();
    chk("rst_p0_count",  64'(count0),  64'(0));
    chk("rst_p1_count",  64'(count1),  64'(0));
    chk("rst_p0_empty",  64'(empty0),  64'(1));
    chk("rst_p1_empty",  64'(empty1),  64'(1));
    chk("rst_p0_aempty", 64'(aempty0), 64'(1));
    chk("rst_p1_aempty", 64'(aempty1), 64'(1));
    chk("rst_p0_full",   64'(full0),   64'(0));
    chk("rst_p1_full",   64'(full1),   64'(0));
    chk("rst_p0_afull",  64'(afull0),  64'(0));
    chk("rst_p1_afull",  64'(afull1),  64'(0));
    chk("rst_p0_rdata",  64'(rdata0),  64'(0));
    chk("rst_p1_rdata",  64'(rdata1),  64'(0));
    chk("rst_p0_valid",  64'(rv0),     64'(0));
    chk("rst_p1_valid",  64'(rv1),     64'(0));
    chk("rst_p0_ovf",    64'(ovf0),    64'(0));
    chk("rst_p1_ovf",    64'(ovf1),    64'(0));
    chk("rst_p0_unf",    64'(unf0),    64'(0));
    chk("rst_p1_unf",    64'(unf1),    64'(0));
  endtask

  // Asynchronous reset asserted mid-cycle; in-flight reads are discarded.
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    model.delete();
    sb0.delete();
    sb1.delete();
    last0 = '0;
    last1 = '0;
    #1;
    checkOutput_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int wp, rp;

    repeat (2) @(negedge clk);
    checkOutput_reset();
    rst = 1'b0;

    // Fill to full, then one overflowing write.
    for (int i = 0; i < D; i++) applyStimulus(1'b1, 1'b0, W'(i));
    applyStimulus(1'b1, 1'b0, 32'hDEAD_0000);

    // Full with simultaneous read and write: stays full, no overflow, order kept across wrap.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 32'h1000_0000 + W'(i));

    // Drain completely, then one underflowing read.
    for (int i = 0; i < D; i++) applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b1, '0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0);

    // Empty with simultaneous read and write: write lands, read rejected.
    applyStimulus(1'b1, 1'b1, 32'h0000_00A5);
    applyStimulus(1'b0, 1'b1, '0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0);

    // Reset during a read burst, then confirm fresh data flows.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, $urandom);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, '0);
    pulse_reset();
    applyStimulus(1'b1, 1'b0, 32'hBEEF_CAFE);
    applyStimulus(1'b0, 1'b1, '0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0);

    // Biased random traffic, bias changed every 200 cycles.
    wp = 50;
    rp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        wp = $urandom_range(20, 90);
        rp = $urandom_range(20, 90);
      end
      applyStimulus($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, $urandom);
    end

    repeat (4) applyStimulus(1'b0, 1'b0, '0);
    chk("p0_sb_drained", 64'(sb0.size()), 64'(0));
    chk("p1_sb_drained", 64'(sb1.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
